// File: rtl/apuf_launch_ctrl_pkg.sv
// apuf_launch_ctrl_pkg: shared defaults and FSM encodings for the arbiter-PUF launch controller
package apuf_launch_ctrl_pkg;
  localparam int DEF_N_STAGES = 64;
  localparam int DEF_SETTLE_CYC = 8;
  localparam int DEF_N_EVAL = 15;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_FIRE = 3'd2;
  localparam logic [2:0] S_RELAX = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
endpackage

// File: rtl/apuf_launch_ctrl_if.sv
// apuf_launch_ctrl_if: request, chain-drive and response signals of the launch controller
interface apuf_launch_ctrl_if import apuf_launch_ctrl_pkg::*; #(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int N_EVAL = DEF_N_EVAL
);
  localparam int CNT_W = $clog2(N_EVAL + 1);
  logic start;
  logic [N_STAGES-1:0] challenge_in;
  logic busy;
  logic [N_STAGES-1:0] sel_out;
  logic launch;
  logic arb_in;
  logic response;
  logic [CNT_W-1:0] ones_cnt;
  logic resp_valid;
  modport master(output start, challenge_in, arb_in,
                 input busy, sel_out, launch, response, ones_cnt, resp_valid);
  modport slave(input start, challenge_in, arb_in,
                output busy, sel_out, launch, response, ones_cnt, resp_valid);
endinterface

// File: rtl/apuf_launch_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchroniser with asynchronous active-high reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/apuf_launch_ctrl.sv
// apuf_launch_ctrl: latches a challenge, fires N_EVAL launch edges into the PUF chain and majority-votes the arbiter
module apuf_launch_ctrl import apuf_launch_ctrl_pkg::*; #(
  parameter int N_STAGES = DEF_N_STAGES,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int N_EVAL = DEF_N_EVAL
) (
  input logic clk,
  input logic rst,
  apuf_launch_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(N_EVAL + 1);
  localparam int TW = $clog2(SETTLE_CYC + 3);
  localparam int EW = N_EVAL > 1 ? $clog2(N_EVAL) : 1;
  if (N_EVAL % 2 == 0) begin : g_odd_chk
    $error("N_EVAL must be odd");
  end
  if (SETTLE_CYC < 1) begin : g_settle_chk
    $error("SETTLE_CYC must be at least 1");
  end
  logic [2:0] state, nxt;
  logic [TW-1:0] timer;
  logic [EW-1:0] eval;
  logic [CNT_W-1:0] vote;
  logic arb_s, tdone, last;
  sync_2ff u_sync (.clk, .rst, .d(bus.arb_in), .q(arb_s));
  assign tdone = timer == '0;
  assign last = eval == EW'(N_EVAL - 1);
  assign nxt = state == S_IDLE  ? (bus.start ? S_LOAD : S_IDLE) :
               state == S_LOAD  ? (tdone ? S_FIRE : S_LOAD) :
               state == S_FIRE  ? (tdone ? S_RELAX : S_FIRE) :
               state == S_RELAX ? (tdone ? (last ? S_DONE : S_FIRE) : S_RELAX) :
               S_IDLE;
  // launch/busy/resp_valid are registered from the next state so the chain never sees decode glitches
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      timer <= '0;
      eval <= '0;
      vote <= '0;
      bus.sel_out <= '0;
      bus.launch <= 1'b0;
      bus.busy <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.ones_cnt <= '0;
      bus.response <= 1'b0;
    end else begin
      state <= nxt;
      timer <= nxt == state ? (tdone ? timer : timer - TW'(1)) :
               nxt == S_FIRE ? TW'(SETTLE_CYC + 1) : TW'(SETTLE_CYC - 1);
      bus.launch <= nxt == S_FIRE;
      bus.busy <= nxt != S_IDLE;
      bus.resp_valid <= nxt == S_DONE;
      if (state == S_IDLE && bus.start) begin
        bus.sel_out <= bus.challenge_in;
        vote <= '0;
        eval <= '0;
      end
      if (state == S_FIRE && tdone) vote <= vote + CNT_W'(arb_s);
      if (state == S_RELAX && tdone && !last) eval <= eval + EW'(1);
      if (nxt == S_DONE) begin
        bus.ones_cnt <= vote;
        bus.response <= vote > CNT_W'(N_EVAL / 2);
      end
    end
endmodule
